// File: rtl/ifb_pkg.sv
// ifb_pkg: shared types and constants for the instruction fetch buffer.
//   XLEN / INSTR_W        address and instruction widths (32)
//   IFB_DEFAULT_RESET_PC  default first fetch address
//   NOP_INSTR             canonical RISC-V NOP (addi x0,x0,0) for benches
//   fetch_entry_t         one prefetch FIFO entry {pc, instr}
//   word_align()          clears address bits [1:0]
package ifb_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    IFB_DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR            = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: DEPTH-entry prefetch FIFO holding {pc, instr} pairs.
// The head entry is kept in its own register so the consumer sees a pure
// register output that only changes on pop, flush, or a push into an
// empty queue.
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset (clears storage and head)
//   flush       empty the FIFO this cycle; overrides push
//   push        write {push_pc, push_instr}; caller guarantees space
//   push_pc     PC of the pushed entry
//   push_instr  instruction of the pushed entry
//   pop         advance the head (ignored when empty)
//   count       occupancy 0..DEPTH
//   head_valid  FIFO not empty
//   head_pc     registered PC of the head entry
//   head_instr  registered instruction of the head entry
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [XLEN-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [CNT_W-1:0]   count,
  output logic               head_valid,
  output logic [XLEN-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  fetch_entry_t     mem_reg [DEPTH];
  fetch_entry_t     head_reg, head_next, push_entry;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next, count_after_pop;
  logic             do_pop, do_push;
  logic [DEPTH-1:0] wr_en;

  assign push_entry      = '{pc: push_pc, instr: push_instr};
  assign do_pop          = pop && (count_reg != '0);
  assign do_push         = push && !flush;
  assign count_after_pop = count_reg - CNT_W'(do_pop);
  assign rd_ptr_next     = rd_ptr_reg + PTR_W'(do_pop);

  // One write enable per storage slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) mem_reg[i] <= push_entry;
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
    count_next  = count_after_pop + CNT_W'(do_push);
    head_next   = head_reg;
    if (flush) begin
      wr_ptr_next = '0;
      count_next  = '0;
      head_next   = '0;
    end else if (do_push && count_after_pop == '0) begin
      // Queue is (or becomes) empty: the incoming word goes straight to the head.
      head_next = push_entry;
    end else if (do_pop) begin
      // With entries left after the pop, the next head is already in storage
      // and is never the slot being written this cycle.
      head_next = mem_reg[rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= flush ? '0 : rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head_pc    = head_reg.pc;
  assign head_instr = head_reg.instr;

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: RISC-V fetch stage. Owns the fetch PC, issues one word
// read per cycle to a 1-cycle synchronous instruction memory while credits
// allow, and queues returned words in ifb_fifo for decode (valid/ready).
// A redirect flushes the queue, drops any returning word and restarts fetch.
// Optional feature macro: IFB_PERF_EN enables the saturating fetch-bubble
// counter; otherwise perf_bubble_cnt is tied to 0.
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-low reset
//   imem_req_valid   read request this cycle (always accepted)
//   imem_addr        word-aligned request address (= fetch PC)
//   imem_rdata       instruction word, valid 1 cycle after the request
//   dec_valid        head entry available
//   dec_ready        decode accepts the head entry
//   dec_instr        head instruction (registered)
//   dec_pc           head PC (registered)
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      restart target, bits [1:0] ignored
//   perf_bubble_cnt  cycles with decode ready but nothing to offer
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFB_DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_bubble_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      inflight_pc_reg, inflight_pc_next;
  logic             inflight_reg, inflight_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;
  logic             issue, dec_fire;

  // A read is only issued when its response is guaranteed a FIFO slot,
  // counting the word already in flight. Pops this cycle are not credited.
  assign credits_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg);
  assign issue        = reset && !redirect_valid
                        && (credits_used < (CNT_W+1)'(DEPTH));

  assign imem_req_valid = issue;
  assign imem_addr      = fetch_pc_reg;
  assign dec_fire       = dec_valid && dec_ready;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    inflight_pc_next = inflight_pc_reg;
    inflight_next    = issue;
    if (redirect_valid) begin
      fetch_pc_next = word_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_next    = fetch_pc_reg + 32'd4;  // wraps FFFF_FFFC -> 0
      inflight_pc_next = fetch_pc_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= word_align(RESET_PC);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
    end
  end

  // Response word is pushed in the cycle it arrives; redirect flushes it.
  ifb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (inflight_reg),
    .push_pc    (inflight_pc_reg),
    .push_instr (imem_rdata),
    .pop        (dec_fire),
    .count      (fifo_count),
    .head_valid (dec_valid),
    .head_pc    (dec_pc),
    .head_instr (dec_instr)
  );

`ifdef IFB_PERF_EN
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_reg <= '0;
    end else if (dec_ready && !dec_valid && (bubble_cnt_reg != '1)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_reg;
`else
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;
  import ifb_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = IFB_DEFAULT_RESET_PC;
`ifdef IFB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] perf_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  // Instruction memory contents: a bijective function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  // 1-cycle registered memory; garbage on cycles with no request.
  always @(posedge clk)
    imem_rdata <= imem_req_valid ? mem_word(imem_addr) : $urandom;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural reference model ----------------
  // Queue of buffered PCs; instructions are implied by mem_word(pc).
  logic [31:0] m_q[$];
  logic [31:0] m_fpc = RST_PC;
  logic [31:0] m_ipc = '0;
  logic        m_infl = 1'b0;
  logic [31:0] m_bub = '0;
  bit          m_issue, m_fire;

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_fpc  = RST_PC;
      m_infl = 1'b0;
      m_ipc  = '0;
      m_bub  = '0;
    end else begin
      m_fire = (m_q.size() != 0) && dec_ready;
      if (dec_ready && m_q.size() == 0 && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      if (redirect_valid) begin
        m_q.delete();
        m_infl = 1'b0;
        m_fpc  = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_issue = (m_q.size() + int'(m_infl)) < DEPTH;
        if (m_fire) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_ipc);
        if (m_issue) begin
          m_ipc  = m_fpc;
          m_fpc  = m_fpc + 32'd4;
          m_infl = 1'b1;
        end else begin
          m_infl = 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      chk1("m_rst_req", imem_req_valid, 1'b0);
      chk("m_rst_addr", imem_addr, RST_PC);
      chk1("m_rst_valid", dec_valid, 1'b0);
      chk("m_rst_pc", dec_pc, 32'h0);
      chk("m_rst_instr", dec_instr, 32'h0);
      chk("m_rst_perf", perf_bubble_cnt, 32'h0);
    end else begin
      chk1("m_req_valid", imem_req_valid,
           !redirect_valid && ((m_q.size() + int'(m_infl)) < DEPTH));
      chk("m_addr", imem_addr, m_fpc);
      chk1("m_dec_valid", dec_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("m_dec_pc", dec_pc, m_q[0]);
        chk("m_dec_instr", dec_instr, mem_word(m_q[0]));
      end
      chk("m_perf", perf_bubble_cnt, PERF_ON ? m_bub : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();   // move to posedge+1, the drive point
    @(posedge clk);
    #1;
  endtask

  task automatic settle();  // let combinational outputs settle before a probe
    #1;
  endtask

  // Leaves us at the drive point of cycle 0 after reset release.
  task automatic release_reset(input logic rdy);
    reset          = 1'b0;
    dec_ready      = rdy;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    int          nreq;
    logic [31:0] got[$];
    logic [31:0] exp_wrap[4];

    reset = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #2;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chk1("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_perf", perf_bubble_cnt, 32'h0);

    // ---- startup stream, then redirect colliding with handshake + push ----
    release_reset(1'b1);
    settle();
    chk1("c0_req", imem_req_valid, 1'b1);
    chk("c0_addr", imem_addr, RST_PC);
    cyc(); settle();
    chk1("c1_valid", dec_valid, 1'b0);
    for (int c = 2; c < 8; c++) begin
      cyc(); settle();
      chk1("start_valid", dec_valid, 1'b1);
      chk("start_pc", dec_pc, RST_PC + 32'(4 * (c - 2)));
      chk("start_instr", dec_instr, mem_word(RST_PC + 32'(4 * (c - 2))));
    end
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    settle();
    chk1("rdA_N_valid", dec_valid, 1'b1);
    chk("rdA_N_pc", dec_pc, 32'd24);
    chk1("rdA_N_req", imem_req_valid, 1'b0);
    cyc(); redirect_valid = 1'b0; settle();
    chk1("rdA_N1_valid", dec_valid, 1'b0);
    chk1("rdA_N1_req", imem_req_valid, 1'b1);
    chk("rdA_N1_addr", imem_addr, 32'h0000_0040);
    cyc(); settle();
    chk1("rdA_N2_valid", dec_valid, 1'b0);
    cyc(); settle();
    chk1("rdA_N3_valid", dec_valid, 1'b1);
    chk("rdA_N3_pc", dec_pc, 32'h0000_0040);
    chk("perf_after_redirect", perf_bubble_cnt, PERF_ON ? 32'd4 : 32'd0);
    cyc(); settle();
    chk("rdA_N4_pc", dec_pc, 32'h0000_0044);

    // ---- stall: decode not ready ----
    release_reset(1'b0);
    settle();
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) begin cyc(); settle(); end
      if (imem_req_valid) nreq++;
    end
    chk("stall_requests", 32'(nreq), 32'd4);
    chk1("stall_req_off", imem_req_valid, 1'b0);
    chk("stall_head_pc", dec_pc, RST_PC);
    cyc(); dec_ready = 1'b1; settle();
    got.delete();
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (c != 0) begin cyc(); settle(); end
      if (dec_valid) got.push_back(dec_pc);
    end
    chk("drain_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) chk("drain_pc", got[i], RST_PC + 32'(4 * i));

    // ---- redirect with 3 queued entries and a read in flight ----
    release_reset(1'b0);
    for (int c = 1; c < 5; c++) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    chk1("rdB_N_valid", dec_valid, 1'b1);
    chk1("rdB_N_req", imem_req_valid, 1'b0);
    cyc(); redirect_valid = 1'b0; dec_ready = 1'b1; settle();
    chk1("rdB_N1_valid", dec_valid, 1'b0);
    chk("rdB_N1_addr", imem_addr, 32'h0000_0100);
    cyc(); settle();
    chk1("rdB_N2_valid", dec_valid, 1'b0);
    cyc(); settle();
    chk1("rdB_N3_valid", dec_valid, 1'b1);
    chk("rdB_N3_pc", dec_pc, 32'h0000_0100);
    cyc(); settle();
    chk("rdB_N4_pc", dec_pc, 32'h0000_0104);

    // ---- redirect near the top of the address space: PC wraps ----
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc(); redirect_valid = 1'b0; settle();
    exp_wrap[0] = 32'hFFFF_FFF8; exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000; exp_wrap[3] = 32'h0000_0004;
    got.delete();
    for (int c = 0; c < 10 && got.size() < 4; c++) begin
      if (c != 0) begin cyc(); settle(); end
      if (dec_valid) got.push_back(dec_pc);
    end
    chk("wrap_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) chk("wrap_pc", got[i], exp_wrap[i]);

    // ---- randomized traffic, checked by the model ----
    for (int c = 0; c < 3000; c++) begin
      cyc();
      reset          = ($urandom_range(0, 399) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
    end
    cyc();
    reset = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b1;
    repeat (5) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction fetch stage for the RISC-V core: owns the fetch PC, issues word reads to the synchronous instruction memory, and queues the returned instructions in a small prefetch FIFO. It presents instructions to decode over a valid/ready handshake, so decode, register-file and immediate-generation logic can stall without losing fetched words. It sits between instruction memory, which has a fixed 1-cycle registered read, and the decode/ImmGen stage. A redirect input serves taken branches and jumps by flushing the buffer and restarting fetch at the target.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  read request this cycle; memory always accepts.
- imem_addr  out  32  byte address of the request; bits [1:0] are always 0.
- imem_rdata  in  32  instruction word, valid exactly 1 cycle after the accepted request.
- dec_valid  out  1  head entry available.
- dec_ready  in  1  decode accepts the head entry.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  PC of the head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart target; bits [1:0] are ignored (forced to 0).
- perf_bubble_cnt  out  32  fetch-bubble counter; see Configuration.

## Operation
- State: fetch_pc, inflight bit, inflight_pc, FIFO of {pc, instr}, and occupancy count 0..DEPTH.
- Issue rule: imem_req_valid = !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, wrapping 32'hFFFF_FFFC → 0; inflight ← 1; inflight_pc ← fetch_pc.
  - With no issue, inflight ← 0.
- Response: in a cycle with inflight=1, the entry {inflight_pc, imem_rdata} is pushed. The credit rule guarantees space, so overflow is impossible.
- Pop: when dec_valid && dec_ready, the head advances. Push and pop in the same cycle leave count unchanged, including when count==DEPTH with pop.
- Redirect has priority over everything in its cycle:
  - FIFO emptied (count←0).
  - Any response arriving that cycle is discarded.
  - No request is issued; inflight ← 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - A dec handshake in the same cycle still counts as consumed.
- No states beyond the above; there is no separate FSM encoding.

## Timing
- Reset asserted, all outputs: imem_req_valid=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, perf_bubble_cnt=0.
  - FIFO storage is reset to 0.
  - Reset mid-operation discards all entries and the in-flight read.
- After reset deassertion:
  - cycle 0: request at RESET_PC.
  - cycle 1: push.
  - cycle 2: dec_valid=1.
- Redirect in cycle N:
  - N+1: request at target.
  - N+3: dec_valid with dec_pc=target.
  - dec_valid=0 in N+1 and N+2.
- Steady state with dec_ready held high: one instruction per cycle, PC stepping by 4.
- dec_instr and dec_pc are driven from registers, with no combinational path from imem_rdata.
- dec_valid has no combinational dependence on dec_ready. Once dec_valid is asserted, dec_instr and dec_pc stay stable until a handshake or a redirect.

## Configuration
- IFB_PERF_EN defined:
  - perf_bubble_cnt increments in every cycle with dec_ready=1 && dec_valid=0 && reset deasserted.
  - It saturates at 32'hFFFF_FFFF and clears only on reset.
- Undefined: perf_bubble_cnt is tied to 0 and no counter logic is instantiated.

## Structure
- Shared package ifb_pkg holds:
  - IFB_DEFAULT_RESET_PC
  - INSTR_W=32, XLEN=32
  - the fetch-entry struct typedef {pc, instr}
  - the NOP constant 32'h0000_0013 for benches
- One sub-module, ifb_fifo: a synchronous DEPTH-entry FIFO with push, pop, flush, count and registered head outputs. The top level holds the PC and credit logic.

## Test plan
- Reset release, dec_ready=1, memory returns addr-derived words → dec_pc sequence 0,4,8,… from cycle 2, one per cycle, instr matching each address.
- dec_ready=0 for 10 cycles → count settles at DEPTH, exactly DEPTH requests issued, imem_req_valid=0 afterwards. Raising dec_ready then yields 4 entries in order with no loss or duplication.
- redirect_valid with redirect_pc=32'h0000_0103 while FIFO holds 3 entries and a read is in flight:
  - dec_valid=0 for 2 cycles;
  - next dec_pc=32'h0000_0100;
  - no stale entries appear.
- Redirect in the same cycle as a dec handshake and a push → handshake consumed, pushed word dropped, fetch restarts at target.
- Redirect to 32'hFFFF_FFF8 → dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With IFB_PERF_EN: hold dec_ready=1 across a reset release and a redirect → perf_bubble_cnt=4 (2 startup bubbles + 2 redirect bubbles). Without the macro: the counter stays 0.
